// File: rtl/tage_history_ctrl_pkg.sv
// Shared types, default geometry and the folded-history update helper
// for the TAGE speculative history controller.
package tage_history_ctrl_pkg;

  // Default predictor geometry
  localparam int GHR_LEN          = 64;
  localparam int TAGE_TABLE_NUM   = 4;
  localparam int TAGE_INDEX_WIDTH = 10;
  localparam int TAGE_TAG_WIDTH   = 8;
  localparam int TAGE_TAG2_WIDTH  = TAGE_TAG_WIDTH - 1;
  localparam int TAGE_HIST_BASE   = 4;
  localparam int TAGE_CKPT_DEPTH  = 8;

  // Widest folded register the helper below can handle
  localparam int FOLD_MAX_W = 32;

  // One in-flight branch snapshot for the default geometry
  typedef struct packed {
    logic [GHR_LEN-1:0]                                ghr;
    logic [TAGE_TABLE_NUM-1:0][TAGE_INDEX_WIDTH-1:0]   csr_idx;
    logic [TAGE_TABLE_NUM-1:0][TAGE_TAG_WIDTH-1:0]     csr_tag;
    logic [TAGE_TABLE_NUM-1:0][TAGE_TAG2_WIDTH-1:0]    csr_tag2;
  } tage_hist_ckpt_t;

  // History length of tagged table t: geometric, capped at the GHR length
  function automatic int hist_len(input int t, input int base, input int ghr_len);
    int l;
    l = base << t;
    return (l > ghr_len) ? ghr_len : l;
  endfunction

  // Shift one bit into a W-bit fold of an L-bit history window.
  // out_bit is the bit leaving the window (ghr[L-1] before the shift);
  // after the rotate it sits at position L mod W, where it is cancelled.
  function automatic logic [FOLD_MAX_W-1:0] fold_update(
    input logic [FOLD_MAX_W-1:0] csr,
    input logic                  new_bit,
    input logic                  out_bit,
    input int unsigned           l,
    input int unsigned           w
  );
    logic [FOLD_MAX_W-1:0] mask;
    logic [FOLD_MAX_W-1:0] rot;
    logic [FOLD_MAX_W-1:0] res;
    mask = (w >= FOLD_MAX_W) ? '1 : ((FOLD_MAX_W'(1) << w) - FOLD_MAX_W'(1));
    rot  = ((csr << 1) | ((csr & mask) >> (w - 1))) & mask;
    res  = rot ^ FOLD_MAX_W'(new_bit) ^ (FOLD_MAX_W'(out_bit) << (l % w));
    return res & mask;
  endfunction

endpackage

// File: rtl/tage_history_ctrl_folded_csr.sv
// One folded-history register (width W over a history window of L bits)
// with synchronous clear, checkpoint load and single-bit update.
module tage_folded_csr
  import tage_history_ctrl_pkg::*;
#(
  parameter int W = 8,
  parameter int L = 8
) (
  input  logic         clk,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_update,
  input  logic         i_new_bit,
  input  logic         i_out_bit,
  output logic [W-1:0] o_csr
);

  logic [W-1:0] r_csr;
  logic [W-1:0] w_base;
  logic [W-1:0] w_next;

  // Load (restore) happens first, then the new bit is folded in on top
  always_comb begin
    w_base = i_load ? i_load_val : r_csr;
    w_next = w_base;
    if (i_update) begin
      w_next = W'(fold_update(FOLD_MAX_W'(w_base), i_new_bit, i_out_bit,
                              L, W));
    end
  end

  // Register with clear taking priority over any update
  always_ff @(posedge clk) begin
    if (i_clear) r_csr <= '0;
    else         r_csr <= w_next;
  end

  assign o_csr = r_csr;

endmodule

// File: rtl/tage_history_ctrl.sv
// Speculative global history and folded-history owner for the TAGE tagged
// tables, with an in-order checkpoint FIFO for misprediction recovery.
module tage_history_ctrl
  import tage_history_ctrl_pkg::*;
#(
  parameter int GHR_LEN     = tage_history_ctrl_pkg::GHR_LEN,
  parameter int NUM_TABLES  = TAGE_TABLE_NUM,
  parameter int INDEX_WIDTH = TAGE_INDEX_WIDTH,
  parameter int TAG_WIDTH   = TAGE_TAG_WIDTH,
  parameter int HIST_BASE   = TAGE_HIST_BASE,
  parameter int CKPT_DEPTH  = TAGE_CKPT_DEPTH
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_pred_valid,
  input  logic                                  i_pred_taken,
  output logic                                  o_full,
  input  logic                                  i_res_valid,
  input  logic                                  i_res_mispred,
  input  logic                                  i_res_outcome,
  output logic [GHR_LEN-1:0]                    o_ghr,
  output logic [NUM_TABLES*INDEX_WIDTH-1:0]     o_csr_idx,
  output logic [NUM_TABLES*TAG_WIDTH-1:0]       o_csr_tag,
  output logic [NUM_TABLES*(TAG_WIDTH-1)-1:0]   o_csr_tag2,
  output logic [NUM_TABLES*INDEX_WIDTH-1:0]     o_fb_csr_idx,
  output logic [NUM_TABLES*TAG_WIDTH-1:0]       o_fb_csr_tag,
  output logic [NUM_TABLES*(TAG_WIDTH-1)-1:0]   o_fb_csr_tag2,
  output logic [$clog2(CKPT_DEPTH):0]           o_count,
  output logic                                  o_underflow
);

  localparam int PTR_W     = $clog2(CKPT_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int TAG2_W    = TAG_WIDTH - 1;
  localparam int IDX_BITS  = NUM_TABLES * INDEX_WIDTH;
  localparam int TAG_BITS  = NUM_TABLES * TAG_WIDTH;
  localparam int TAG2_BITS = NUM_TABLES * TAG2_W;

  typedef struct packed {
    logic [GHR_LEN-1:0]   ghr;
    logic [IDX_BITS-1:0]  csr_idx;
    logic [TAG_BITS-1:0]  csr_tag;
    logic [TAG2_BITS-1:0] csr_tag2;
  } ckpt_t;

  ckpt_t              r_ckpt_mem [CKPT_DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic [GHR_LEN-1:0] r_ghr;
  logic               r_underflow;

  logic [IDX_BITS-1:0]  w_csr_idx;
  logic [TAG_BITS-1:0]  w_csr_tag;
  logic [TAG2_BITS-1:0] w_csr_tag2;
  ckpt_t                w_head_ckpt;
  ckpt_t                w_cur_ckpt;

  logic               w_empty;
  logic               w_full;
  logic               w_res_ok;
  logic               w_mispred;
  logic               w_pop;
  logic               w_push;
  logic               w_update;
  logic               w_new_bit;
  logic               w_clear;
  logic [GHR_LEN-1:0] w_base_ghr;

  assign w_clear     = !rst_n;
  assign w_head_ckpt = r_ckpt_mem[r_head];
  assign w_cur_ckpt  = '{ghr: r_ghr, csr_idx: w_csr_idx,
                         csr_tag: w_csr_tag, csr_tag2: w_csr_tag2};

  // Event arbitration: a mispredict squashes any same-cycle push, and a
  // correct resolve frees a slot for a push arriving while full
  always_comb begin
    w_empty    = (r_count == '0);
    w_full     = (r_count == CNT_W'(CKPT_DEPTH));
    w_res_ok   = i_res_valid && !w_empty;
    w_mispred  = w_res_ok && i_res_mispred;
    w_pop      = w_res_ok && !i_res_mispred;
    w_push     = i_pred_valid && !w_mispred && (!w_full || w_pop);
    w_update   = w_push || w_mispred;
    w_new_bit  = w_mispred ? i_res_outcome : i_pred_taken;
    w_base_ghr = w_mispred ? w_head_ckpt.ghr : r_ghr;
  end

  // Speculative GHR: restore from the head snapshot on mispredict, then shift
  always_ff @(posedge clk) begin
    if (!rst_n)        r_ghr <= '0;
    else if (w_update) r_ghr <= GHR_LEN'({w_base_ghr, w_new_bit});
  end

  // Checkpoint FIFO pointers and occupancy; a mispredict empties the FIFO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_mispred) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Checkpoint storage holds the pre-update history of each pushed branch
  always_ff @(posedge clk) begin
    if (w_push) r_ckpt_mem[r_tail] <= w_cur_ckpt;
  end

  // Sticky flag for a resolve that found no in-flight branch
  always_ff @(posedge clk) begin
    if (!rst_n)                       r_underflow <= 1'b0;
    else if (i_res_valid && w_empty)  r_underflow <= 1'b1;
  end

  // Three folded registers per tagged table, each over that table's window
  generate
    for (genvar gi = 0; gi < NUM_TABLES; gi++) begin : g_table
      localparam int L_T = hist_len(gi, HIST_BASE, GHR_LEN);

      tage_folded_csr #(.W(INDEX_WIDTH), .L(L_T)) u_csr_idx (
        .clk        (clk),
        .i_clear    (w_clear),
        .i_load     (w_mispred),
        .i_load_val (w_head_ckpt.csr_idx[gi*INDEX_WIDTH +: INDEX_WIDTH]),
        .i_update   (w_update),
        .i_new_bit  (w_new_bit),
        .i_out_bit  (w_base_ghr[L_T-1]),
        .o_csr      (w_csr_idx[gi*INDEX_WIDTH +: INDEX_WIDTH])
      );

      tage_folded_csr #(.W(TAG_WIDTH), .L(L_T)) u_csr_tag (
        .clk        (clk),
        .i_clear    (w_clear),
        .i_load     (w_mispred),
        .i_load_val (w_head_ckpt.csr_tag[gi*TAG_WIDTH +: TAG_WIDTH]),
        .i_update   (w_update),
        .i_new_bit  (w_new_bit),
        .i_out_bit  (w_base_ghr[L_T-1]),
        .o_csr      (w_csr_tag[gi*TAG_WIDTH +: TAG_WIDTH])
      );

      tage_folded_csr #(.W(TAG2_W), .L(L_T)) u_csr_tag2 (
        .clk        (clk),
        .i_clear    (w_clear),
        .i_load     (w_mispred),
        .i_load_val (w_head_ckpt.csr_tag2[gi*TAG2_W +: TAG2_W]),
        .i_update   (w_update),
        .i_new_bit  (w_new_bit),
        .i_out_bit  (w_base_ghr[L_T-1]),
        .o_csr      (w_csr_tag2[gi*TAG2_W +: TAG2_W])
      );
    end
  endgenerate

  assign o_ghr         = r_ghr;
  assign o_csr_idx     = w_csr_idx;
  assign o_csr_tag     = w_csr_tag;
  assign o_csr_tag2    = w_csr_tag2;
  assign o_fb_csr_idx  = w_empty ? '0 : w_head_ckpt.csr_idx;
  assign o_fb_csr_tag  = w_empty ? '0 : w_head_ckpt.csr_tag;
  assign o_fb_csr_tag2 = w_empty ? '0 : w_head_ckpt.csr_tag2;
  assign o_count       = r_count;
  assign o_full        = w_full;
  assign o_underflow   = r_underflow;

endmodule

// File: tb/tb_tage_history_ctrl.sv
// Scoreboard bench for tage_history_ctrl: a history/checkpoint model kept as
// a plain GHR plus a queue of GHR snapshots; folds are recomputed from scratch.
module tb_tage_history_ctrl;

  localparam int GL  = 64;
  localparam int NT  = 2;
  localparam int IW  = 4;
  localparam int TW  = 8;
  localparam int T2W = TW - 1;
  localparam int HB  = 4;
  localparam int CD  = 4;
  localparam int CW  = $clog2(CD) + 1;

  logic                clk;
  logic                rst_n;
  logic                i_pred_valid, i_pred_taken;
  logic                i_res_valid, i_res_mispred, i_res_outcome;
  logic                o_full, o_underflow;
  logic [GL-1:0]       o_ghr;
  logic [NT*IW-1:0]    o_csr_idx, o_fb_csr_idx;
  logic [NT*TW-1:0]    o_csr_tag, o_fb_csr_tag;
  logic [NT*T2W-1:0]   o_csr_tag2, o_fb_csr_tag2;
  logic [CW-1:0]       o_count;

  tage_history_ctrl #(
    .GHR_LEN(GL), .NUM_TABLES(NT), .INDEX_WIDTH(IW), .TAG_WIDTH(TW),
    .HIST_BASE(HB), .CKPT_DEPTH(CD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_pred_valid  (i_pred_valid),
    .i_pred_taken  (i_pred_taken),
    .o_full        (o_full),
    .i_res_valid   (i_res_valid),
    .i_res_mispred (i_res_mispred),
    .i_res_outcome (i_res_outcome),
    .o_ghr         (o_ghr),
    .o_csr_idx     (o_csr_idx),
    .o_csr_tag     (o_csr_tag),
    .o_csr_tag2    (o_csr_tag2),
    .o_fb_csr_idx  (o_fb_csr_idx),
    .o_fb_csr_tag  (o_fb_csr_tag),
    .o_fb_csr_tag2 (o_fb_csr_tag2),
    .o_count       (o_count),
    .o_underflow   (o_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [GL-1:0]    ghr;
    logic [NT*TW-1:0] idx, tag, tag2, fidx, ftag, ftag2;
    int               cnt;
    bit               full;
    bit               uf;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [GL-1:0] m_ghr;
  logic [GL-1:0] m_q[$];
  bit            m_uf;
  int            checks = 0;
  int            errors = 0;
  int            txn    = 0;

  // Fold by definition: XOR of the w-bit chunks of the newest l history bits
  function automatic logic [31:0] fold_of(input logic [GL-1:0] g, input int l, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < l; i++) r[i % w] = r[i % w] ^ g[i];
    return r;
  endfunction

  function automatic logic [NT*TW-1:0] pack_fold(input logic [GL-1:0] g, input int w);
    logic [NT*TW-1:0] res;
    logic [31:0]      tmp;
    int               l;
    res = '0;
    for (int t = 0; t < NT; t++) begin
      l = HB << t;
      if (l > GL) l = GL;
      tmp = fold_of(g, l, w);
      for (int b = 0; b < w; b++) res[t*w + b] = tmp[b];
    end
    return res;
  endfunction

  function automatic exp_t snapshot();
    exp_t          e;
    logic [GL-1:0] h;
    e.ghr  = m_ghr;
    e.idx  = pack_fold(m_ghr, IW);
    e.tag  = pack_fold(m_ghr, TW);
    e.tag2 = pack_fold(m_ghr, T2W);
    if (m_q.size() > 0) begin
      h       = m_q[0];
      e.fidx  = pack_fold(h, IW);
      e.ftag  = pack_fold(h, TW);
      e.ftag2 = pack_fold(h, T2W);
    end else begin
      e.fidx  = '0;
      e.ftag  = '0;
      e.ftag2 = '0;
    end
    e.cnt  = m_q.size();
    e.full = (m_q.size() == CD);
    e.uf   = m_uf;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock of stimulus: drive, record the visible state, advance the model
  task automatic cycle(input bit rst, input bit pv, input bit pt,
                       input bit rv, input bit rm, input bit ro);
    @(posedge clk);
    #2;
    rst_n = !rst; i_pred_valid = pv; i_pred_taken = pt;
    i_res_valid = rv; i_res_mispred = rm; i_res_outcome = ro;
    sb.push_back(snapshot());
    $display("txn %0d rst=%0d pred=%0d/%0d res=%0d mis=%0d out=%0d depth=%0d",
             txn, rst, pv, pt, rv, rm, ro, m_q.size());
    txn++;
    if (rst) begin
      m_ghr = '0;
      m_q.delete();
      m_uf = 1'b0;
    end else begin
      if (rv && m_q.size() == 0) m_uf = 1'b1;
      if (rv && m_q.size() > 0 && rm) begin
        m_ghr = {m_q[0][GL-2:0], ro};
        m_q.delete();
      end else begin
        if (rv && m_q.size() > 0) void'(m_q.pop_front());
        if (pv && m_q.size() < CD) begin
          m_q.push_back(m_ghr);
          m_ghr = {m_ghr[GL-2:0], pt};
        end
      end
    end
  endtask

  // Monitor: every falling edge the DUT presents a state; compare if expected
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("ghr",       64'(o_ghr),         64'(mon_e.ghr));
      chk("csr_idx",   64'(o_csr_idx),     64'(mon_e.idx[NT*IW-1:0]));
      chk("csr_tag",   64'(o_csr_tag),     64'(mon_e.tag));
      chk("csr_tag2",  64'(o_csr_tag2),    64'(mon_e.tag2[NT*T2W-1:0]));
      chk("fb_idx",    64'(o_fb_csr_idx),  64'(mon_e.fidx[NT*IW-1:0]));
      chk("fb_tag",    64'(o_fb_csr_tag),  64'(mon_e.ftag));
      chk("fb_tag2",   64'(o_fb_csr_tag2), 64'(mon_e.ftag2[NT*T2W-1:0]));
      chk("count",     64'(o_count),       64'(mon_e.cnt));
      chk("full",      64'(o_full),        64'(mon_e.full));
      chk("underflow", 64'(o_underflow),   64'(mon_e.uf));
    end
  end

  initial begin
    int wait_cnt;
    bit r, pv, rv, rm;
    rst_n = 1'b0;
    i_pred_valid = 0; i_pred_taken = 0;
    i_res_valid = 0; i_res_mispred = 0; i_res_outcome = 0;
    repeat (2) @(posedge clk);
    m_ghr = '0; m_q.delete(); m_uf = 1'b0;

    // Reset state, then five taken pushes with a correct resolve on 2..5
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    repeat (4) cycle(0, 1, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // T,T,N then mispredict back to the first snapshot with outcome N
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Fill to full, push while full alone, then push with a correct resolve
    cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Push together with a mispredict: push is dropped
    cycle(0, 1, 0, 1, 1, 1);
    cycle(0, 0, 0, 0, 0, 0);

    // Resolve while empty sets the sticky underflow flag
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Randomized traffic with rare resets
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 79) == 0);
      pv = ($urandom_range(0, 9) < 6);
      rv = ($urandom_range(0, 9) < 4);
      rm = ($urandom_range(0, 3) == 0);
      cycle(r, pv, 1'($urandom), rv, rm, 1'($urandom));
    end
    cycle(0, 0, 0, 0, 0, 0);

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    checks++;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d records left, required 0", sb.size());
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
